ins_ddr_reader: RTL and testbench

- Upstream feeder of the instruction cache.
- Accepts a burst-read request (address, length) from the cache and issues one burst read to the DDR controller's user port.
- Packs each returned beat as {instruction, beat index, valid} into an internal FIFO, which the cache drains with a read enable.
- Reports burst progress through ins_reading.

---
 rtl/ap_ddr_pkg.sv | 22 ++
 rtl/ins_ddr_reader_if.sv | 22 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/ins_ddr_reader.sv | 145 ++++++++++++++
 tb/tb_ins_ddr_reader.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ap_ddr_pkg.sv
// Shared definitions for the instruction-side DDR reader: FSM encoding and
// the layout of one beat-FIFO entry.
package ap_ddr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SPACE,
    ST_REQ,
    ST_READ,
    ST_DONE
  } rd_state_e;

  localparam int ISA_WIDTH_DEF = 30;
  localparam int CNT_WIDTH     = 8;

  // Entry layout: {data, beat index, valid}
  localparam int VALID_BIT = 0;
  localparam int CNT_LSB   = 1;
  localparam int DATA_LSB  = CNT_LSB + CNT_WIDTH;
  localparam int ENTRY_W   = ISA_WIDTH_DEF + DATA_LSB;

endpackage

// File: rtl/ins_ddr_reader_if.sv
// DDR controller user-port read channel as seen by the instruction reader.
interface ins_ddr_reader_if #(
  parameter int AW = 28,
  parameter int DW = 30
);
  logic          ddr_rd_req;
  logic [AW-1:0] ddr_rd_addr;
  logic [7:0]    ddr_rd_len;
  logic          ddr_rd_ack;
  logic [DW-1:0] ddr_rd_data;
  logic          ddr_rd_data_valid;

  modport master (
    output ddr_rd_req, ddr_rd_addr, ddr_rd_len,
    input  ddr_rd_ack, ddr_rd_data, ddr_rd_data_valid
  );

  modport slave (
    input  ddr_rd_req, ddr_rd_addr, ddr_rd_len,
    output ddr_rd_ack, ddr_rd_data, ddr_rd_data_valid
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data (one-cycle read latency) and
// an occupancy count; a pop in the same cycle frees the slot for a push at full.
module sync_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic [AW:0]      count_o,
  output logic             drop_o
);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] dout_q;
  logic             full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == DEPTH_V);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign drop_o  = push_i && !do_push;
  assign dout_o  = dout_q;
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        dout_q   <= mem_q[rd_ptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/ins_ddr_reader.sv
// Instruction-cache feeder: one DDR burst per cache request, beats packed
// into a FIFO the cache drains.
//   state      | meaning
//   IDLE       | waiting for an armed request
//   WAIT_SPACE | waiting until the FIFO can absorb the whole burst
//   REQ        | ddr_rd_req held until ack
//   READ       | writing returned beats into the FIFO
//   DONE       | burst finished, back to IDLE next cycle
module ins_ddr_reader
  import ap_ddr_pkg::*;
#(
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int ISA_WIDTH      = ISA_WIDTH_DEF,
  parameter int FIFO_DEPTH     = 256,
  parameter int FIFO_AW        = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ins_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0] ins_read_addr,
  input  logic [7:0]                ins_read_len,
  output logic                      ins_reading,
  input  logic                      ddr_to_ic_rd_en,
  output logic                      ddr_to_ic_empty,
  output logic [ISA_WIDTH+8:0]      ins_fifo_to_cache,
  output logic                      overflow_err,
  ins_ddr_reader_if.master          ddr
);
  localparam int          EW      = ISA_WIDTH + DATA_LSB;
  localparam logic [FIFO_AW:0] DEPTH_V = (FIFO_AW+1)'(FIFO_DEPTH);

  rd_state_e                 state_q, state_d;
  logic [DDR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                len_q, len_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      armed_q, armed_d;
  logic                      reading_q, reading_d;
  logic                      flush_q, flush_d;
  logic                      ovf_q, ovf_d;

  logic          push;
  logic [EW-1:0] entry;
  logic [FIFO_AW:0] fifo_count, free;
  logic          fifo_drop;

  assign free = DEPTH_V - fifo_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      armed_q   <= 1'b1;
      reading_q <= 1'b0;
      flush_q   <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      reading_q <= reading_d;
      flush_q   <= flush_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    reading_d = reading_q;
    flush_d   = flush_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    entry     = '0;
    entry[VALID_BIT]              = 1'b1;
    entry[CNT_LSB +: CNT_WIDTH]   = cnt_q;
    entry[DATA_LSB +: ISA_WIDTH]  = ddr.ddr_rd_data;

    if (!ins_read_req) armed_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (ins_read_req && armed_q) begin
          addr_d  = ins_read_addr;
          len_d   = ins_read_len;
          cnt_d   = '0;
          armed_d = 1'b0;
          flush_d = 1'b0;
          if (ins_read_len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_WAIT_SPACE;
            reading_d = 1'b1;
          end
        end
      end
      ST_WAIT_SPACE: if (free >= {1'b0, len_q}) state_d = ST_REQ;
      ST_REQ:        if (ddr.ddr_rd_ack) state_d = ST_READ;
      ST_READ: begin
        if (ddr.ddr_rd_data_valid) begin
          push  = 1'b1;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q - 8'd1) begin
            state_d   = ST_DONE;
            reading_d = 1'b0;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Stale beats of a burst cut short by reset are silently discarded.
    if (ddr.ddr_rd_data_valid && state_q != ST_READ && !flush_q) ovf_d = 1'b1;
    if (fifo_drop) ovf_d = 1'b1;
  end

  assign ddr.ddr_rd_req  = (state_q == ST_REQ);
  assign ddr.ddr_rd_addr = addr_q;
  assign ddr.ddr_rd_len  = len_q;
  assign ins_reading     = reading_q;
  assign overflow_err    = ovf_q;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (entry),
    .pop_i   (ddr_to_ic_rd_en),
    .dout_o  (ins_fifo_to_cache),
    .empty_o (ddr_to_ic_empty),
    .count_o (fifo_count),
    .drop_o  (fifo_drop)
  );
endmodule

// File: tb/tb_ins_ddr_reader.sv
// Directed self-checking bench for ins_ddr_reader plus a standalone sync_fifo
// instance for the push-while-full corner the reader cannot reach on its own.
module tb_ins_ddr_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ins_read_req;
  logic [27:0] ins_read_addr;
  logic [7:0]  ins_read_len;
  logic        ins_reading;
  logic        rd_en;
  logic        empty;
  logic [38:0] dout;
  logic        ovf;

  ins_ddr_reader_if #(.AW(28), .DW(30)) ddr_if ();

  ins_ddr_reader #(
    .DDR_ADDR_WIDTH (28),
    .ISA_WIDTH      (30),
    .FIFO_DEPTH     (256),
    .FIFO_AW        (8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ins_read_req      (ins_read_req),
    .ins_read_addr     (ins_read_addr),
    .ins_read_len      (ins_read_len),
    .ins_reading       (ins_reading),
    .ddr_to_ic_rd_en   (rd_en),
    .ddr_to_ic_empty   (empty),
    .ins_fifo_to_cache (dout),
    .overflow_err      (ovf),
    .ddr               (ddr_if)
  );

  logic        f_push, f_pop, f_empty, f_drop;
  logic [15:0] f_din, f_dout;
  logic [8:0]  f_count;

  sync_fifo #(.WIDTH(16), .DEPTH(256), .AW(8)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (f_push),
    .din_i   (f_din),
    .pop_i   (f_pop),
    .dout_o  (f_dout),
    .empty_o (f_empty),
    .count_o (f_count),
    .drop_o  (f_drop)
  );

  typedef struct {
    logic [27:0] addr;
    logic [7:0]  len;
    logic [29:0] base;
    int          dly;
    bit          gap;
    logic [38:0] exp_first;
    logic [38:0] exp_last;
  } vec_t;

  vec_t vecs [4];
  vec_t rec;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [38:0] ent(input logic [29:0] d, input logic [7:0] c);
    return {d, c, 1'b1};
  endfunction

  task automatic wait_req(input string tag);
    int w;
    w = 0;
    while (!ddr_if.ddr_rd_req && w < 20) begin
      tick();
      w++;
    end
    chk({tag, " req_seen"}, ddr_if.ddr_rd_req, 1);
  endtask

  task automatic run_burst(input vec_t v, input string tag);
    ins_read_addr = v.addr;
    ins_read_len  = v.len;
    ins_read_req  = 1'b1;
    tick();
    ins_read_req  = 1'b0;
    chk({tag, " reading_on"}, ins_reading, 1);
    wait_req(tag);
    chk({tag, " rd_addr"}, ddr_if.ddr_rd_addr, v.addr);
    chk({tag, " rd_len"}, ddr_if.ddr_rd_len, v.len);
    repeat (v.dly) tick();
    chk({tag, " req_held"}, ddr_if.ddr_rd_req, 1);
    ddr_if.ddr_rd_ack = 1'b1;
    tick();
    ddr_if.ddr_rd_ack = 1'b0;
    chk({tag, " req_drop"}, ddr_if.ddr_rd_req, 0);
    for (int k = 0; k < int'(v.len); k++) begin
      ddr_if.ddr_rd_data       = v.base + 30'(k);
      ddr_if.ddr_rd_data_valid = 1'b1;
      tick();
      ddr_if.ddr_rd_data_valid = 1'b0;
      if (k == 0 && v.len > 1) chk({tag, " reading_mid"}, ins_reading, 1);
      if (k == int'(v.len) - 1) chk({tag, " reading_off"}, ins_reading, 0);
      if (v.gap) tick();
    end
    chk({tag, " not_empty"}, empty, 0);
    rd_en = 1'b1;
    for (int k = 0; k < int'(v.len); k++) begin
      tick();
      chk({tag, " entry"}, dout, ent(v.base + 30'(k), 8'(k)));
      if (k == 0) chk({tag, " first"}, dout, v.exp_first);
      if (k == int'(v.len) - 1) chk({tag, " last"}, dout, v.exp_last);
    end
    chk({tag, " drained"}, empty, 1);
    tick();
    chk({tag, " pop_empty_hold"}, dout, v.exp_last);
    rd_en = 1'b0;
    chk({tag, " no_ovf"}, ovf, 0);
  endtask

  // Acts as the DDR controller: acks any request at once and streams
  // ddr_rd_len beats base, base+1, ... back to back.
  task automatic ddr_slave(input int cycles, input logic [29:0] base, output int nreq);
    int left, idx;
    left = 0;
    idx  = 0;
    nreq = 0;
    for (int c = 0; c < cycles; c++) begin
      ddr_if.ddr_rd_ack        = 1'b0;
      ddr_if.ddr_rd_data_valid = 1'b0;
      if (ddr_if.ddr_rd_req) begin
        ddr_if.ddr_rd_ack = 1'b1;
        nreq++;
        left = int'(ddr_if.ddr_rd_len);
        idx  = 0;
      end else if (left > 0) begin
        ddr_if.ddr_rd_data       = base + 30'(idx);
        ddr_if.ddr_rd_data_valid = 1'b1;
        idx++;
        left--;
      end
      tick();
    end
    ddr_if.ddr_rd_ack        = 1'b0;
    ddr_if.ddr_rd_data_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w;
    logic seen;
    logic [15:0] fexp;

    vecs[0] = '{28'h40,      8'd4,   30'h0A0,      3, 1'b1, 39'h14001,      39'h14607};
    vecs[1] = '{28'h1234560, 8'd1,   30'h3FFFFFFF, 0, 1'b0, 39'h7FFFFFFE01, 39'h7FFFFFFE01};
    vecs[2] = '{28'hFFFFFFF, 8'd16,  30'h100,      1, 1'b0, 39'h20001,      39'h21E1F};
    vecs[3] = '{28'h0,       8'd255, 30'h1000,     2, 1'b0, 39'h200001,     39'h21FDFD};

    rst = 1'b1;
    ins_read_req = 1'b0; ins_read_addr = '0; ins_read_len = '0; rd_en = 1'b0;
    ddr_if.ddr_rd_ack = 1'b0; ddr_if.ddr_rd_data = '0; ddr_if.ddr_rd_data_valid = 1'b0;
    f_push = 1'b0; f_pop = 1'b0; f_din = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst empty", empty, 1);
    chk("rst reading", ins_reading, 0);
    chk("rst rd_req", ddr_if.ddr_rd_req, 0);
    chk("rst rd_addr", ddr_if.ddr_rd_addr, 0);
    chk("rst rd_len", ddr_if.ddr_rd_len, 0);
    chk("rst dout", dout, 0);
    chk("rst ovf", ovf, 0);

    for (int i = 0; i < 4; i++) run_burst(vecs[i], $sformatf("vec%0d", i));

    // One burst per held request; re-armed after a single low cycle.
    ins_read_addr = 28'h55; ins_read_len = 8'd2; ins_read_req = 1'b1;
    ddr_slave(50, 30'h111, n);
    chk("held one_burst", n, 1);
    chk("held reading_off", ins_reading, 0);
    ins_read_req = 1'b0;
    tick();
    ins_read_req = 1'b1;
    ddr_slave(20, 30'h222, n);
    ins_read_req = 1'b0;
    chk("rearm second_burst", n, 1);
    rd_en = 1'b1;
    tick(); chk("held e0", dout, 39'h22201);
    tick(); chk("held e1", dout, 39'h22403);
    tick(); chk("rearm e0", dout, 39'h44401);
    tick(); chk("rearm e1", dout, 39'h44603);
    rd_en = 1'b0;
    chk("held drained", empty, 1);

    // Back-pressure: 200 entries resident, a 128-beat burst needs 72 pops.
    ins_read_addr = 28'h200; ins_read_len = 8'd200; ins_read_req = 1'b1;
    tick();
    ins_read_req = 1'b0;
    ddr_slave(210, 30'h2000, n);
    chk("prefill burst", n, 1);
    ins_read_len = 8'd128; ins_read_req = 1'b1;
    tick();
    ins_read_req = 1'b0;
    repeat (5) tick();
    chk("bp wait", ddr_if.ddr_rd_req, 0);
    rd_en = 1'b1;
    repeat (71) tick();
    rd_en = 1'b0;
    repeat (3) tick();
    chk("bp 71 pops", ddr_if.ddr_rd_req, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    w = 0;
    while (!ddr_if.ddr_rd_req && w < 5) begin tick(); w++; end
    chk("bp req", ddr_if.ddr_rd_req, 1);
    chk("bp latency", w, 1);
    ddr_slave(140, 30'h3000, n);
    chk("bp burst", n, 1);
    chk("bp no_ovf", ovf, 0);
    chk("bp full not_empty", empty, 0);
    rd_en = 1'b1;
    for (int k = 0; k < 256; k++) begin
      tick();
      if (k == 0)   chk("bp drain first", dout, 39'h409091);
      if (k == 127) chk("bp drain old_last", dout, 39'h418F8F);
      if (k == 128) chk("bp drain new_first", dout, 39'h600001);
      if (k == 255) chk("bp drain new_last", dout, 39'h60FEFF);
    end
    rd_en = 1'b0;
    chk("bp drained", empty, 1);

    // Standalone FIFO: full, drop at full, concurrent push/pop at full and empty.
    f_push = 1'b1;
    for (int i = 0; i < 256; i++) begin
      f_din = 16'h100 + 16'(i);
      tick();
    end
    chk("fifo count_full", f_count, 256);
    f_din = 16'hDEAD;
    #1;
    chk("fifo drop_at_full", f_drop, 1);
    tick();
    f_push = 1'b0;
    chk("fifo count_after_drop", f_count, 256);
    f_push = 1'b1; f_pop = 1'b1;
    for (int j = 0; j < 4; j++) begin
      f_din = 16'h500 + 16'(j);
      tick();
      chk("fifo full_pushpop data", f_dout, 16'h100 + 16'(j));
      chk("fifo full_pushpop count", f_count, 256);
      chk("fifo full_pushpop empty", f_empty, 0);
    end
    f_push = 1'b0;
    for (int k = 0; k < 256; k++) begin
      tick();
      fexp = (k < 252) ? 16'h104 + 16'(k) : 16'h500 + 16'(k - 252);
      chk("fifo order", f_dout, fexp);
    end
    chk("fifo drained", f_empty, 1);
    f_push = 1'b1; f_din = 16'h0077;
    tick();
    f_push = 1'b0; f_pop = 1'b0;
    chk("fifo empty_pushpop count", f_count, 1);
    chk("fifo empty_pushpop hold", f_dout, 16'h503);
    f_pop = 1'b1;
    tick();
    f_pop = 1'b0;
    chk("fifo empty_pushpop data", f_dout, 16'h0077);

    // len=0 is a no-op burst; FSM must be back in IDLE two cycles later.
    ins_read_addr = 28'h77; ins_read_len = 8'd0; ins_read_req = 1'b1;
    tick();
    ins_read_req = 1'b0;
    chk("len0 reading", ins_reading, 0);
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (ddr_if.ddr_rd_req) seen = 1'b1;
      tick();
    end
    chk("len0 no_req", seen, 0);
    ins_read_req = 1'b1;
    tick();
    ins_read_req = 1'b0;
    tick();
    ins_read_len = 8'd1; ins_read_req = 1'b1;
    tick();
    chk("len0 idle_in_2", ins_reading, 1);
    ins_read_req = 1'b0;
    ddr_slave(10, 30'h5A5, n);
    chk("len0 follow burst", n, 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("len0 follow entry", dout, 39'hB4A01);
    ddr_if.ddr_rd_data = 30'h1234; ddr_if.ddr_rd_data_valid = 1'b1;
    tick();
    ddr_if.ddr_rd_data_valid = 1'b0;
    tick();
    chk("stray ovf", ovf, 1);
    chk("stray empty", empty, 1);
    chk("stray dout", dout, 39'hB4A01);

    // Reset after 2 of 8 beats; the rest of the stream arrives in IDLE.
    ins_read_addr = 28'h99; ins_read_len = 8'd8; ins_read_req = 1'b1;
    tick();
    ins_read_req = 1'b0;
    wait_req("rstmid");
    ddr_if.ddr_rd_ack = 1'b1;
    tick();
    ddr_if.ddr_rd_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ddr_if.ddr_rd_data = 30'h600 + 30'(k); ddr_if.ddr_rd_data_valid = 1'b1;
      tick();
    end
    rst = 1'b1;
    ddr_if.ddr_rd_data = 30'h602;
    tick();
    rst = 1'b0;
    chk("rstmid empty", empty, 1);
    chk("rstmid reading", ins_reading, 0);
    chk("rstmid rd_req", ddr_if.ddr_rd_req, 0);
    chk("rstmid ovf_cleared", ovf, 0);
    for (int k = 3; k < 8; k++) begin
      ddr_if.ddr_rd_data = 30'h600 + 30'(k);
      tick();
    end
    ddr_if.ddr_rd_data_valid = 1'b0;
    tick();
    chk("rstmid late_beats ovf", ovf, 0);
    chk("rstmid late_beats empty", empty, 1);
    rec = '{28'hABCDEF, 8'd3, 30'h700, 0, 1'b0, 39'hE0001, 39'hE0405};
    run_burst(rec, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
